// File: rtl/bitstream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_arbiter_pkg
// Description : Shared types and constants for the bitstream arbiter: the
//               control state encoding and the 4-bit code-length decode.
// Revision    : 1.0 - initial release
// ============================================================================
package bitstream_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SWITCH = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    // A length field of zero encodes a full 16-bit code.
    localparam int LEN16 = 16;

    function automatic logic [4:0] code_len(input logic [3:0] len);
        return (len == 4'd0) ? 5'(LEN16) : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitstream_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin grant register. A new grant is
//               only issued while no grant is held; a held grant survives
//               while its lock is high, or while the requester is still
//               requesting and strobing codes.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_req/i_lock/i_en [1:0] - per-requester request, lock, strobe
//               i_arb_en      - arbitration permitted this cycle
//               i_clear       - drop any held grant
//               o_gnt [1:0]   - registered one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic [1:0] i_en,
    input  logic       i_arb_en,
    input  logic       i_clear,
    output logic [1:0] o_gnt
);

    logic [1:0] r_gnt;
    logic       r_last;   // index of the most recently granted requester
    logic [1:0] w_keep;
    logic [1:0] w_pick;

    // Grant is kept while locked; otherwise it needs both req and en.
    assign w_keep = r_gnt & (i_lock | (i_req & i_en));

    // Priority goes to the requester after the last one granted.
    assign w_pick[0] = i_req[0] & (r_last | ~i_req[1]);
    assign w_pick[1] = i_req[1] & (~r_last | ~i_req[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt  <= 2'b00;
            r_last <= 1'b1;
        end else if (i_clear) begin
            r_gnt  <= 2'b00;
        end else if (r_gnt != 2'b00) begin
            r_gnt  <= w_keep;
        end else if (i_arb_en && (i_req != 2'b00)) begin
            r_gnt  <= w_pick;
            r_last <= w_pick[1];
        end
    end

    assign o_gnt = r_gnt;

endmodule
`default_nettype wire

// File: rtl/bitstream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bitstream_arbiter
// Description : Shares one bit packer between a header generator (req 0) and
//               a VLC coder (req 1), and ping-pongs the packer between two
//               CPU-configured output buffers.
// Ports       : clk, reset            - clock, asynchronous active-high reset
//               req/lock/en/bits/len  - per-requester code interface
//               gnt/rdy               - grant and forwarded packer ready
//               bs_*                  - packer code and address interface
//               cfg_*, start, rel     - CPU configuration and buffer release
//               irq, filled, buf_idx, bit_count - status
// Revision    : 1.0 - initial release
// ============================================================================
module bitstream_arbiter
    import bitstream_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              en0,
    input  logic              en1,
    input  logic [15:0]       bits0,
    input  logic [15:0]       bits1,
    input  logic [3:0]        len0,
    input  logic [3:0]        len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rdy0,
    output logic              rdy1,
    input  logic              bs_rdy,
    input  logic              bs_full,
    output logic              bs_en,
    output logic [15:0]       bs_bits,
    output logic [3:0]        bs_len,
    output logic              bs_setaddr,
    output logic [ADDR_W-1:0] bs_abase,
    output logic [ADDR_W-1:0] bs_aend,
    input  logic [ADDR_W-1:0] cfg_base0,
    input  logic [ADDR_W-1:0] cfg_base1,
    input  logic [ADDR_W-1:0] cfg_size,
    input  logic              start,
    input  logic              rel,
    input  logic              rel_idx,
    output logic              irq,
    output logic [1:0]        filled,
    output logic              buf_idx,
    output logic [31:0]       bit_count
);

    state_t              r_state;
    logic                r_buf_idx;
    logic [1:0]          r_filled;
    logic [31:0]         r_bit_count;
    logic                r_setaddr;
    logic [ADDR_W-1:0]   r_abase;
    logic [ADDR_W-1:0]   r_aend;

    logic [1:0]          w_gnt;
    logic                w_run;
    logic [1:0]          w_rel_mask;
    logic [1:0]          w_filled_rel;
    logic [1:0]          w_cur_mask;
    logic                w_load_idx;
    logic [ADDR_W-1:0]   w_load_base;
    logic                w_count;

    assign w_run = (r_state == ST_RUN);

    // Grants are dropped on the edge into SWITCH so SWITCH itself forwards nothing.
    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (reset),
        .i_req    ({req1, req0}),
        .i_lock   ({lock1, lock0}),
        .i_en     ({en1, en0}),
        .i_arb_en (w_run & ~bs_full),
        .i_clear  ((w_run & bs_full) | (r_state == ST_SWITCH)),
        .o_gnt    (w_gnt)
    );

    // Release is applied before SWITCH/WAIT look at the flags.
    assign w_rel_mask   = rel ? (rel_idx ? 2'b10 : 2'b01) : 2'b00;
    assign w_filled_rel = r_filled & ~w_rel_mask;
    assign w_cur_mask   = r_buf_idx ? 2'b10 : 2'b01;

    // SWITCH loads the other buffer; IDLE and WAIT load the current one.
    assign w_load_idx  = (r_state == ST_SWITCH) ? ~r_buf_idx : r_buf_idx;
    assign w_load_base = w_load_idx ? cfg_base1 : cfg_base0;

    assign w_count = bs_en & bs_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_buf_idx   <= 1'b0;
            r_filled    <= 2'b00;
            r_bit_count <= 32'd0;
            r_setaddr   <= 1'b0;
            r_abase     <= '0;
            r_aend      <= '0;
        end else begin
            r_filled  <= w_filled_rel;
            r_setaddr <= 1'b0;
            if (w_count) begin
                r_bit_count <= r_bit_count + {27'd0, code_len(bs_len)};
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_LOAD;
                        r_setaddr   <= 1'b1;
                        r_abase     <= w_load_base;
                        r_aend      <= w_load_base + cfg_size;
                        r_bit_count <= 32'd0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bs_full) begin
                        r_state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    r_filled  <= w_filled_rel | w_cur_mask;
                    r_buf_idx <= ~r_buf_idx;
                    if (!w_filled_rel[w_load_idx]) begin
                        r_state   <= ST_LOAD;
                        r_setaddr <= 1'b1;
                        r_abase   <= w_load_base;
                        r_aend    <= w_load_base + cfg_size;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!w_filled_rel[r_buf_idx]) begin
                        r_state   <= ST_LOAD;
                        r_setaddr <= 1'b1;
                        r_abase   <= w_load_base;
                        r_aend    <= w_load_base + cfg_size;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational forwarding from the granted requester.
    assign bs_en   = w_run & ((w_gnt[0] & en0) | (w_gnt[1] & en1));
    assign bs_bits = w_gnt[1] ? bits1 : (w_gnt[0] ? bits0 : 16'd0);
    assign bs_len  = w_gnt[1] ? len1  : (w_gnt[0] ? len0  : 4'd0);
    assign rdy0    = w_run & w_gnt[0] & bs_rdy;
    assign rdy1    = w_run & w_gnt[1] & bs_rdy;
    assign gnt0    = w_gnt[0];
    assign gnt1    = w_gnt[1];

    assign bs_setaddr = r_setaddr;
    assign bs_abase   = r_abase;
    assign bs_aend    = r_aend;
    assign filled     = r_filled;
    assign buf_idx    = r_buf_idx;
    assign bit_count  = r_bit_count;
    assign irq        = |r_filled;

endmodule
`default_nettype wire

// File: tb/tb_bitstream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitstream_arbiter
// Description : Directed self-checking bench for bitstream_arbiter: a vector
//               table for arbitration/forwarding plus hand-written sequences
//               for buffer switching, release and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitstream_arbiter;

    logic        clk, reset;
    logic        req0, req1, lock0, lock1, en0, en1;
    logic [15:0] bits0, bits1;
    logic [3:0]  len0, len1;
    logic        gnt0, gnt1, rdy0, rdy1;
    logic        bs_rdy, bs_full, bs_en, bs_setaddr;
    logic [15:0] bs_bits;
    logic [3:0]  bs_len;
    logic [31:0] bs_abase, bs_aend;
    logic [31:0] cfg_base0, cfg_base1, cfg_size;
    logic        start, rel, rel_idx;
    logic        irq, buf_idx;
    logic [1:0]  filled;
    logic [31:0] bit_count;

    int n_checks = 0;
    int n_fail   = 0;

    bitstream_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .en0(en0), .en1(en1), .bits0(bits0), .bits1(bits1),
        .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1),
        .bs_rdy(bs_rdy), .bs_full(bs_full), .bs_en(bs_en),
        .bs_bits(bs_bits), .bs_len(bs_len), .bs_setaddr(bs_setaddr),
        .bs_abase(bs_abase), .bs_aend(bs_aend),
        .cfg_base0(cfg_base0), .cfg_base1(cfg_base1), .cfg_size(cfg_size),
        .start(start), .rel(rel), .rel_idx(rel_idx),
        .irq(irq), .filled(filled), .buf_idx(buf_idx), .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req0, req1, lock0, lock1, en0, en1;
        logic [15:0] bits0, bits1;
        logic [3:0]  len0, len1;
        logic        rdy;
        logic        e_gnt0, e_gnt1, e_en;
        logic [15:0] e_bits;
        logic [3:0]  e_len;
        logic        e_rdy0, e_rdy1;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // req0 req1 lock0 lock1 en0 en1 bits0 bits1 len0 len1 rdy | gnt0 gnt1 en bits len rdy0 rdy1 cnt
        vecs[0] = '{1,1,1,0,0,1,16'hA5A5,16'h5A5A,4'd3,4'd5,1, 1,0,0,16'hA5A5,4'd3,1,0,32'd0};
        vecs[1] = '{1,1,1,0,1,1,16'h1234,16'h5A5A,4'd0,4'd5,1, 1,0,1,16'h1234,4'd0,1,0,32'd16};
        vecs[2] = '{1,1,1,0,1,1,16'h000F,16'h5A5A,4'd4,4'd5,0, 1,0,1,16'h000F,4'd4,0,0,32'd16};
        vecs[3] = '{1,1,0,0,0,1,16'h000F,16'h5A5A,4'd4,4'd5,1, 0,0,0,16'h0000,4'd0,0,0,32'd16};
        vecs[4] = '{1,1,0,1,0,0,16'h000F,16'h5A5A,4'd4,4'd5,1, 0,1,0,16'h5A5A,4'd5,0,1,32'd16};
        vecs[5] = '{1,1,0,1,1,1,16'hFFFF,16'hBEEF,4'd0,4'd8,1, 0,1,1,16'hBEEF,4'd8,0,1,32'd24};
        vecs[6] = '{1,0,0,0,1,1,16'hFFFF,16'hBEEF,4'd0,4'd8,1, 0,0,0,16'h0000,4'd0,0,0,32'd32};
        vecs[7] = '{1,0,0,0,1,0,16'h1111,16'hBEEF,4'd0,4'd8,1, 1,0,1,16'h1111,4'd0,1,0,32'd32};
        vecs[8] = '{1,0,0,0,1,0,16'h1111,16'hBEEF,4'd0,4'd8,1, 1,0,1,16'h1111,4'd0,1,0,32'd48};

        reset = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; en0 = 0; en1 = 0;
        bits0 = 0; bits1 = 0; len0 = 0; len1 = 0;
        bs_rdy = 0; bs_full = 0; start = 0; rel = 0; rel_idx = 0;
        cfg_base0 = 32'h1000; cfg_base1 = 32'h2000; cfg_size = 32'h10;

        // Reset state
        tick(); tick();
        check("rst_gnt",     {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_setaddr", {31'd0, bs_setaddr}, 32'd0);
        check("rst_abase",   bs_abase, 32'd0);
        check("rst_aend",    bs_aend, 32'd0);
        check("rst_irq",     {31'd0, irq}, 32'd0);
        check("rst_filled",  {30'd0, filled}, 32'd0);
        check("rst_bufidx",  {31'd0, buf_idx}, 32'd0);
        check("rst_count",   bit_count, 32'd0);
        reset = 1'b0;

        // Start: one-cycle LOAD with buffer 0 addresses, then RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_setaddr", {31'd0, bs_setaddr}, 32'd1);
        check("load_abase",   bs_abase, 32'h1000);
        check("load_aend",    bs_aend, 32'h1010);
        tick();
        check("run_setaddr",  {31'd0, bs_setaddr}, 32'd0);
        check("run_abase",    bs_abase, 32'h1000);

        // Arbitration / forwarding table
        for (int i = 0; i < 9; i++) begin
            req0 = vecs[i].req0;   req1 = vecs[i].req1;
            lock0 = vecs[i].lock0; lock1 = vecs[i].lock1;
            en0 = vecs[i].en0;     en1 = vecs[i].en1;
            bits0 = vecs[i].bits0; bits1 = vecs[i].bits1;
            len0 = vecs[i].len0;   len1 = vecs[i].len1;
            bs_rdy = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].e_gnt0});
            check($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].e_gnt1});
            check($sformatf("v%0d_bs_en", i), {31'd0, bs_en}, {31'd0, vecs[i].e_en});
            check($sformatf("v%0d_bits", i), {16'd0, bs_bits}, {16'd0, vecs[i].e_bits});
            check($sformatf("v%0d_len", i), {28'd0, bs_len}, {28'd0, vecs[i].e_len});
            check($sformatf("v%0d_rdy0", i), {31'd0, rdy0}, {31'd0, vecs[i].e_rdy0});
            check($sformatf("v%0d_rdy1", i), {31'd0, rdy1}, {31'd0, vecs[i].e_rdy1});
            check($sformatf("v%0d_count", i), bit_count, vecs[i].e_cnt);
        end

        // Drop everything; grant released
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; en0 = 0; en1 = 0;
        tick();
        check("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // First switch with both buffers free -> LOAD buffer 1
        bs_full = 1'b1;
        tick();
        bs_full = 1'b0;
        check("sw1_gnt",    {30'd0, gnt1, gnt0}, 32'd0);
        check("sw1_bs_en",  {31'd0, bs_en}, 32'd0);
        check("sw1_filled", {30'd0, filled}, 32'd0);
        tick();
        check("sw1_filled_after", {30'd0, filled}, 32'd1);
        check("sw1_bufidx",  {31'd0, buf_idx}, 32'd1);
        check("sw1_irq",     {31'd0, irq}, 32'd1);
        check("sw1_setaddr", {31'd0, bs_setaddr}, 32'd1);
        check("sw1_abase",   bs_abase, 32'h2000);
        check("sw1_aend",    bs_aend, 32'h2010);
        tick();
        check("sw1_run_setaddr", {31'd0, bs_setaddr}, 32'd0);

        // Second switch with buffer 0 still filled -> WAIT
        bs_full = 1'b1;
        tick();
        bs_full = 1'b0;
        tick();
        check("wait_filled",  {30'd0, filled}, 32'd3);
        check("wait_bufidx",  {31'd0, buf_idx}, 32'd0);
        check("wait_setaddr", {31'd0, bs_setaddr}, 32'd0);
        tick();
        check("wait_hold_setaddr", {31'd0, bs_setaddr}, 32'd0);
        rel = 1'b1; rel_idx = 1'b0;
        tick();
        rel = 1'b0;
        check("rel_filled",  {30'd0, filled}, 32'd2);
        check("rel_setaddr", {31'd0, bs_setaddr}, 32'd1);
        check("rel_abase",   bs_abase, 32'h1000);
        check("rel_aend",    bs_aend, 32'h1010);
        tick();

        // Release in the same cycle as SWITCH -> straight to LOAD
        bs_full = 1'b1;
        tick();
        bs_full = 1'b0;
        rel = 1'b1; rel_idx = 1'b1;
        tick();
        rel = 1'b0;
        check("relsw_filled",  {30'd0, filled}, 32'd1);
        check("relsw_bufidx",  {31'd0, buf_idx}, 32'd1);
        check("relsw_setaddr", {31'd0, bs_setaddr}, 32'd1);
        check("relsw_abase",   bs_abase, 32'h2000);
        tick();

        // start outside IDLE is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ign_count",   bit_count, 32'd48);
        check("start_ign_setaddr", {31'd0, bs_setaddr}, 32'd0);

        // Mid-RUN asynchronous reset while requester 1 holds the grant
        req1 = 1; lock1 = 1; en1 = 1; len1 = 4'd2; bs_rdy = 0;
        tick();
        check("pre_rst_gnt1",  {31'd0, gnt1}, 32'd1);
        check("pre_rst_bs_en", {31'd0, bs_en}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_gnt1",    {31'd0, gnt1}, 32'd0);
        check("arst_bs_en",   {31'd0, bs_en}, 32'd0);
        check("arst_setaddr", {31'd0, bs_setaddr}, 32'd0);
        check("arst_filled",  {30'd0, filled}, 32'd0);
        check("arst_irq",     {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_no_arb_gnt1", {31'd0, gnt1}, 32'd0);
        check("idle_no_bs_en",    {31'd0, bs_en}, 32'd0);
        req1 = 0; lock1 = 0; en1 = 0;

        // Eight 16-bit codes from a fresh start -> 128 bits
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_count", bit_count, 32'd0);
        check("restart_abase", bs_abase, 32'h1000);
        tick();
        req0 = 1; lock0 = 1; en0 = 0; len0 = 4'd0; bits0 = 16'hC0DE;
        tick();
        check("codes_gnt0", {31'd0, gnt0}, 32'd1);
        en0 = 1; bs_rdy = 1;
        repeat (8) tick();
        check("codes_count", bit_count, 32'd128);
        en0 = 0; lock0 = 0; req0 = 0;
        tick();
        check("codes_release", {30'd0, gnt1, gnt0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
